phase_recover: RTL and testbench

- Inverse of the Box-Muller cos/sin stage: takes a first-quadrant (cos, sin) sample pair in the same format the cos/sin multiplier produces and recovers the 14-bit phase code that generated it.
- Iterative CORDIC vectoring engine (atan2), one micro-rotation per clock, with valid/ready handshakes on both sides.
- Used as a self-check / loopback monitor on the noise generator's trig path and as a standalone phase detector.

---
 rtl/phase_recover_if.sv | 25 ++
 rtl/phase_recover.sv | 118 +++++++++++
 tb/tb_phase_recover.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/phase_recover_if.sv
// Sample/result stream bundle for phase_recover: a (cos, sin) pair in and a
// (phase, magnitude, zero) result out, each with its own valid/ready handshake.
interface phase_recover_if #(
    parameter int DW = 20
);
    logic [15:0]   cos_i;
    logic [15:0]   sin_i;
    logic          in_valid;
    logic          in_ready;
    logic [13:0]   angle_o;
    logic [DW-1:0] mag_o;
    logic          zero_o;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output cos_i, sin_i, in_valid, out_ready,
        input  in_ready, angle_o, mag_o, zero_o, out_valid
    );

    modport slave (
        input  cos_i, sin_i, in_valid, out_ready,
        output in_ready, angle_o, mag_o, zero_o, out_valid
    );
endinterface

// File: rtl/phase_recover.sv
// CORDIC vectoring engine recovering a 14-bit first-quadrant phase code from an
// unsigned (cos, sin) pair, one micro-rotation per clock.
module phase_recover #(
    parameter int ITER = 16,
    parameter int DW   = 20,
    parameter int ZW   = 18
) (
    input  logic           clk,
    input  logic           reset,
    phase_recover_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0]    LAST = 5'(ITER - 1);
    localparam logic [ZW+1:0] RND  = (ZW + 2)'(1) << (ZW - 15);

    // atan(2^-i) in units of (pi/2)/2^18; scaled up when ZW is wider than 18.
    localparam logic [17:0] AT18 [32] = '{
        18'd131072, 18'd77376, 18'd40884, 18'd20753, 18'd10417, 18'd5213,
        18'd2607,   18'd1304,  18'd652,   18'd326,   18'd163,   18'd81,
        18'd41,     18'd20,    18'd10,    18'd5,     18'd3,     18'd1,
        18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
        18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0
    };

    function automatic logic [ZW+1:0] scale_at(input logic [17:0] t);
        logic [31:0] w;
        w = {14'd0, t} << (ZW - 18);
        return w[ZW+1:0];
    endfunction

    logic [1:0]           state;
    logic [4:0]           i;
    logic signed [DW-1:0] x, y;
    // z spans 0..2^ZW for a quarter turn plus early-iteration overshoot,
    // hence two bits above ZW.
    logic signed [ZW+1:0] z;

    logic signed [DW-1:0] x_sh, y_sh, x_nx, y_nx;
    logic signed [ZW+1:0] at_i, z_nx;
    logic [ZW+1:0]        z_rnd, r;
    logic [13:0]          ang_nx;

    always_comb begin
        x_sh = x >>> i;
        y_sh = y >>> i;
        at_i = scale_at(AT18[i]);
        if (!y[DW-1]) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + at_i;
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - at_i;
        end

        z_rnd = z_nx + RND;
        r     = z_rnd >> (ZW - 14);
        if (bus.zero_o || z_nx[ZW+1])
            ang_nx = '0;
        else if (|r[ZW+1:14])
            ang_nx = '1;
        else
            ang_nx = r[13:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            i             <= '0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.angle_o   <= '0;
            bus.mag_o     <= '0;
            bus.zero_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        x            <= DW'(bus.cos_i);
                        y            <= DW'(bus.sin_i);
                        z            <= '0;
                        i            <= '0;
                        bus.zero_o   <= (bus.cos_i == 16'd0) && (bus.sin_i == 16'd0);
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    i <= i + 5'd1;
                    if (i == LAST) begin
                        bus.angle_o   <= ang_nx;
                        bus.mag_o     <= x_nx;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_recover.sv
// Bench for phase_recover: vector table plus latency, backpressure, reset and
// loopback-sweep sequences, results checked through an expectation queue.
module tb_phase_recover;
    localparam int ITER = 16;
    localparam int DW   = 20;
    localparam int ZW   = 18;
    localparam real PI  = 3.14159265358979;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    phase_recover_if #(.DW(DW)) bus ();

    phase_recover #(.ITER(ITER), .DW(DW), .ZW(ZW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] c;
        logic [15:0] s;
        int          ang;
        int          atol;
        logic        zero;
        bit          chk_mag;
        int          mag;
        int          mtol;
    } vec_t;

    vec_t vecs [9];
    vec_t stage;
    vec_t got_e;
    vec_t sb [$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(input logic [15:0] c, input logic [15:0] s,
                                input int ang, input int atol, input logic zero,
                                input bit chk_mag, input int mag, input int mtol);
        vec_t v;
        v.c = c; v.s = s; v.ang = ang; v.atol = atol; v.zero = zero;
        v.chk_mag = chk_mag; v.mag = mag; v.mtol = mtol;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        nvec++;
        if (act < exp - tol || act > exp + tol) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Expectations enter the queue on the accept edge and leave on the result handshake.
    always @(negedge clk) begin
        if (!reset && bus.in_valid && bus.in_ready)
            sb.push_back(stage);
    end

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_result: got angle %0d, want no result", bus.angle_o);
            end else begin
                got_e = sb.pop_front();
                chk("angle", int'(bus.angle_o), got_e.ang, got_e.atol);
                chk("zero", int'(bus.zero_o), int'(got_e.zero), 0);
                if (got_e.chk_mag)
                    chk("mag", int'(bus.mag_o), got_e.mag, got_e.mtol);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input vec_t v);
        stage        = v;
        bus.cos_i    = v.c;
        bus.sin_i    = v.s;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        present(v);
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: got in_ready 0 after %0d cycles, want 1", n);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk(name, seen, 0, 0);
    endtask

    initial begin
        int   n;
        real  th;
        int   ci, si;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cos_i     = '0;
        bus.sin_i     = '0;

        vecs[0] = mk(16'h8000, 16'h0000, 0,     1, 1'b0, 1'b1, 53962,  4);
        vecs[1] = mk(16'h5A82, 16'h5A82, 8192,  2, 1'b0, 1'b1, 53960,  6);
        vecs[2] = mk(16'h6ED9, 16'h4000, 5461,  2, 1'b0, 1'b1, 53960,  6);
        vecs[3] = mk(16'h0000, 16'h8000, 16383, 0, 1'b0, 1'b1, 53962,  6);
        vecs[4] = mk(16'h0000, 16'h0000, 0,     0, 1'b1, 1'b1, 0,      0);
        vecs[5] = mk(16'hFFFF, 16'hFFFF, 8192,  2, 1'b0, 1'b1, 152623, 8);
        vecs[6] = mk(16'hFFFF, 16'h0000, 0,     1, 1'b0, 1'b1, 107921, 6);
        vecs[7] = mk(16'h0001, 16'h0000, 0,     0, 1'b0, 1'b0, 0,      0);
        vecs[8] = mk(16'h0000, 16'h0001, 16383, 0, 1'b0, 1'b0, 0,      0);

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_in_ready",  int'(bus.in_ready),  1, 0);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_angle",     int'(bus.angle_o),   0, 0);
        chk("rst_mag",       int'(bus.mag_o),     0, 0);
        chk("rst_zero",      int'(bus.zero_o),    0, 0);

        // First pair: out_valid must rise exactly ITER edges after the accept edge.
        present(vecs[0]);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", n, ITER, 0);
        drain();

        for (int k = 1; k < 9; k++)
            send(vecs[k]);
        drain();

        // Backpressure with a competing input pulse.
        bus.out_ready = 1'b0;
        send(vecs[1]);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_valid_rise", int'(bus.out_valid), 1, 0);
        present(vecs[2]);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_out_valid", int'(bus.out_valid), 1, 0);
            chk("bp_in_ready",  int'(bus.in_ready),  0, 0);
            chk("bp_angle",     int'(bus.angle_o),   8192, 2);
            chk("bp_mag",       int'(bus.mag_o),     53960, 6);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready",  int'(bus.in_ready),  1, 0);
        chk("bp_release_out_valid", int'(bus.out_valid), 0, 0);
        chk("bp_queue_empty", sb.size(), 0, 0);
        quiet_window("bp_no_extra_result", ITER + 4);

        // Reset while iteration 7 is on the next edge.
        send(vecs[2]);
        repeat (7) tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        chk("midrun_in_ready",  int'(bus.in_ready),  1, 0);
        chk("midrun_out_valid", int'(bus.out_valid), 0, 0);
        chk("midrun_angle",     int'(bus.angle_o),   0, 0);
        quiet_window("midrun_no_result", ITER + 4);
        send(vecs[2]);
        drain();

        // Loopback through an ideal cos/sin stage.
        for (int code = 0; code <= 16383; code += 127) begin
            th = real'(code) * (PI / 2.0) / 16384.0;
            ci = $rtoi(32768.0 * $cos(th) + 0.5);
            si = $rtoi(32768.0 * $sin(th) + 0.5);
            send(mk(16'(ci), 16'(si), code, 4, 1'b0, 1'b0, 0, 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary by 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
